// File: rtl/triroc_sc_loader.sv
`default_nettype none
// ============================================================================
// Module   : triroc_sc_loader
// Purpose  : Serializes host config words MSB-first into the TRIROC
//            slow-control register, driving ck_sr/rstb_sr/select/load_sc.
// Option   : TRIROC_SC_READBACK_EN adds CRC-16-CCITT on sent/readback bits.
// Revision : 1.0 - initial release
// ============================================================================
module triroc_sc_loader #(
  parameter int WIDTH      = 1256,
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 8,
  parameter int LOAD_HOLD  = 8
) (
  input  logic        ck_sys,
  input  logic        rst_sys,
  input  logic        start,
  input  logic        rst_req,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        busy,
  output logic        done,
  output logic        ck_sr,
  output logic        rstb_sr,
  output logic        sr_in,
  input  logic        sr_out,
  output logic        select,
  output logic        load_sc,
  output logic [15:0] tx_crc,
  output logic [15:0] rb_crc
);

  localparam int c_BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_CNT_MAX = (CLK_DIV > RST_CYCLES)
                           ? ((CLK_DIV > LOAD_HOLD) ? CLK_DIV : LOAD_HOLD)
                           : ((RST_CYCLES > LOAD_HOLD) ? RST_CYCLES : LOAD_HOLD);
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_FETCH = 3'd2,
    S_SHIFT = 3'd3,
    S_LOAD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [c_BIT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [4:0]           r_word_bit, w_word_bit_nxt;
  logic [30:0]          r_word, w_word_nxt;
  logic                 r_ck_sr, w_ck_sr_nxt;
  logic                 r_sr_in, w_sr_in_nxt;
  logic                 r_rstb_sr, w_rstb_sr_nxt;
  logic                 r_load_sc, w_load_sc_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_select, w_select_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_rise;
  logic                 w_start_acc;
  logic                 w_last_bit;

  assign w_last_bit = (r_bit_cnt == c_BIT_W'(WIDTH - 1));

  always_ff @(posedge ck_sys or posedge rst_sys) begin
    if (rst_sys) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_word_bit <= '0;
      r_word     <= '0;
      r_ck_sr    <= 1'b0;
      r_sr_in    <= 1'b0;
      r_rstb_sr  <= 1'b1;
      r_load_sc  <= 1'b1;
      r_busy     <= 1'b0;
      r_select   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_word_bit <= w_word_bit_nxt;
      r_word     <= w_word_nxt;
      r_ck_sr    <= w_ck_sr_nxt;
      r_sr_in    <= w_sr_in_nxt;
      r_rstb_sr  <= w_rstb_sr_nxt;
      r_load_sc  <= w_load_sc_nxt;
      r_busy     <= w_busy_nxt;
      r_select   <= w_select_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_word_bit_nxt = r_word_bit;
    w_word_nxt     = r_word;
    w_ck_sr_nxt    = r_ck_sr;
    w_sr_in_nxt    = r_sr_in;
    w_rstb_sr_nxt  = r_rstb_sr;
    w_load_sc_nxt  = r_load_sc;
    w_busy_nxt     = r_busy;
    w_select_nxt   = r_select;
    w_done_nxt     = 1'b0;
    w_rise         = 1'b0;
    w_start_acc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc    = 1'b1;
          w_busy_nxt     = 1'b1;
          w_select_nxt   = 1'b1;
          w_bit_cnt_nxt  = '0;
          w_word_bit_nxt = '0;
          w_cnt_nxt      = '0;
          if (rst_req) begin
            w_state_nxt   = S_RST;
            w_rstb_sr_nxt = 1'b0;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_RST: begin
        if (r_cnt == c_CNT_W'(RST_CYCLES - 1)) begin
          w_rstb_sr_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_FETCH;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_FETCH: begin
        // ck_sr sits low here, so a slow host just stretches the low phase
        if (s_valid) begin
          w_word_nxt  = s_data[30:0];
          w_sr_in_nxt = s_data[31];
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
          if (w_last_bit) w_load_sc_nxt = 1'b0;
        end
      end
      S_SHIFT: begin
        if (r_cnt != c_CNT_W'(CLK_DIV - 1)) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else if (!r_ck_sr) begin
          w_ck_sr_nxt = 1'b1;
          w_rise      = 1'b1;
          w_cnt_nxt   = '0;
          if (w_last_bit) w_state_nxt = S_LOAD;
        end else begin
          w_ck_sr_nxt   = 1'b0;
          w_cnt_nxt     = '0;
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_word_bit == 5'd31) begin
            w_word_bit_nxt = '0;
            w_state_nxt    = S_FETCH;
          end else begin
            w_word_bit_nxt = r_word_bit + 1'b1;
            w_word_nxt     = {r_word[29:0], 1'b0};
            w_sr_in_nxt    = r_word[30];
            if (r_bit_cnt == c_BIT_W'(WIDTH - 2)) w_load_sc_nxt = 1'b0;
          end
        end
      end
      S_LOAD: begin
        // Entered on the final rising edge; finish its high phase, then hold load_sc
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_CNT_W'(CLK_DIV - 1)) w_ck_sr_nxt = 1'b0;
        if (r_cnt == c_CNT_W'(LOAD_HOLD - 1)) begin
          w_ck_sr_nxt   = 1'b0;
          w_load_sc_nxt = 1'b1;
          w_done_nxt    = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        w_busy_nxt   = 1'b0;
        w_select_nxt = 1'b0;
        w_sr_in_nxt  = 1'b0;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign s_ready = (r_state == S_FETCH);
  assign busy    = r_busy;
  assign done    = r_done;
  assign ck_sr   = r_ck_sr;
  assign rstb_sr = r_rstb_sr;
  assign sr_in   = r_sr_in;
  assign select  = r_select;
  assign load_sc = r_load_sc;

`ifdef TRIROC_SC_READBACK_EN
  logic [15:0] r_tx_crc;
  logic [15:0] r_rb_crc;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // sr_out as seen in the cycle before the rise is what the register shifts out
  always_ff @(posedge ck_sys or posedge rst_sys) begin
    if (rst_sys) begin
      r_tx_crc <= '0;
      r_rb_crc <= '0;
    end else if (w_start_acc) begin
      r_tx_crc <= 16'hFFFF;
      r_rb_crc <= 16'hFFFF;
    end else if (w_rise) begin
      r_tx_crc <= crc16_step(r_tx_crc, r_sr_in);
      r_rb_crc <= crc16_step(r_rb_crc, sr_out);
    end
  end

  assign tx_crc = r_tx_crc;
  assign rb_crc = r_rb_crc;
`else
  logic w_unused;
  assign w_unused = ^{sr_out, w_rise, w_start_acc};
  assign tx_crc   = 16'h0000;
  assign rb_crc   = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_triroc_sc_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_triroc_sc_loader
// Purpose  : Directed + randomized passes checked against a word-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_triroc_sc_loader;
  localparam int W    = 40;
  localparam int DIV  = 2;
  localparam int RSTC = 8;
  localparam int LH   = 8;

  logic        ck_sys  = 1'b0;
  logic        rst_sys = 1'b1;
  logic        start   = 1'b0;
  logic        rst_req = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data  = 32'h0;
  logic        s_ready, busy, done, ck_sr, rstb_sr, sr_in, sr_out, select, load_sc;
  logic [15:0] tx_crc, rb_crc;

  always #5 ck_sys = ~ck_sys;

  triroc_sc_loader #(
    .WIDTH(W), .CLK_DIV(DIV), .RST_CYCLES(RSTC), .LOAD_HOLD(LH)
  ) dut (
    .ck_sys(ck_sys), .rst_sys(rst_sys), .start(start), .rst_req(rst_req),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .busy(busy),
    .done(done), .ck_sr(ck_sr), .rstb_sr(rstb_sr), .sr_in(sr_in),
    .sr_out(sr_out), .select(select), .load_sc(load_sc),
    .tx_crc(tx_crc), .rb_crc(rb_crc)
  );

  // Model of the TRIROC shift register itself
  logic [W-1:0] sc_reg = '0;
  always @(posedge ck_sr or negedge rstb_sr) begin
    if (!rstb_sr) sc_reg <= '0;
    else          sc_reg <= {sc_reg[W-2:0], sr_in};
  end
  assign sr_out = sc_reg[W-1];

  // Free-running observers; the stimulus block works with differences
  int   rises = 0, rstb_low = 0, load_low = 0, ck_high = 0, done_pulses = 0, bad_rises = 0;
  logic prev_ck = 1'b0;
  bit   q_bits[$];
  bit   q_load[$];
  int   q_rstb_at[$];
  int   q_loadlow_at[$];
`ifdef TRIROC_SC_READBACK_EN
  logic prev_sro = 1'b0;
  bit   q_rb[$];
`endif

  always @(negedge ck_sys) begin
    if (ck_sr && !prev_ck) begin
      rises++;
      q_bits.push_back(sr_in);
      q_load.push_back(load_sc);
      q_rstb_at.push_back(rstb_low);
      q_loadlow_at.push_back(load_low);
`ifdef TRIROC_SC_READBACK_EN
      q_rb.push_back(prev_sro);
`endif
      if (!rstb_sr || !select || !busy) bad_rises++;
    end
    if (!rstb_sr) rstb_low++;
    if (!load_sc) load_low++;
    if (ck_sr)    ck_high++;
    if (done)     done_pulses++;
    prev_ck = ck_sr;
`ifdef TRIROC_SC_READBACK_EN
    prev_sro = sr_out;
`endif
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First W bits of the word stream, MSB of word 0 first
  function automatic logic [W-1:0] expect_bits(input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] cat;
    cat = {w0, w1};
    return cat[63 -: W];
  endfunction

`ifdef TRIROC_SC_READBACK_EN
  function automatic logic [15:0] crc_of(input logic [W-1:0] v);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = W - 1; k >= 0; k--)
      c = {c[14:0], 1'b0} ^ ((c[15] ^ v[k]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction
`endif

  task automatic send_word(input logic [31:0] w, input int stall);
    int n;
    int hi;
    n  = 0;
    hi = 0;
    if (stall > 0) begin
      s_valid = 1'b0;
      while (!s_ready && n < 1000) begin @(negedge ck_sys); n++; end
      for (int i = 0; i < stall; i++) begin
        if (ck_sr) hi++;
        start = (i == stall / 2);
        @(negedge ck_sys);
      end
      start = 1'b0;
      check("stall_ck_low", 64'(hi), 64'd0);
    end
    s_data  = w;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 1000) begin @(negedge ck_sys); n++; end
    check("handshake_in_time", 64'(n < 1000), 64'd1);
    @(negedge ck_sys);
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic run_pass(input int id, input logic rq, input logic [31:0] w0,
                          input logic [31:0] w1, input int stall,
                          output logic [15:0] tx_o, output logic [15:0] rb_o);
    int r0, rl0, ll0, ch0, dp0, br0, n;
    logic [W-1:0] exp_bits, obs_bits, load_n;
    string p;
`ifdef TRIROC_SC_READBACK_EN
    logic [W-1:0] obs_rb;
    obs_rb = '0;
`endif
    p   = $sformatf("p%0d", id);
    r0  = rises;    rl0 = rstb_low; ll0 = load_low;
    ch0 = ck_high;  dp0 = done_pulses; br0 = bad_rises;
    exp_bits = expect_bits(w0, w1);
    s_data  = w0;
    s_valid = 1'b1;
    start   = 1'b1;
    rst_req = rq;
    @(negedge ck_sys);
    start   = 1'b0;
    rst_req = 1'b0;
    send_word(w0, 0);
    send_word(w1, stall);
    n = 0;
    while (!done && n < 2000) begin @(negedge ck_sys); n++; end
    check({p, "_done_seen"}, 64'(done), 64'd1);
    @(negedge ck_sys);
    check({p, "_busy_done_drop"}, 64'({busy, done, select}), 64'd0);
    repeat (4) @(negedge ck_sys);
    obs_bits = '0;
    load_n   = '0;
    for (int k = 0; k < W; k++) begin
      if (r0 + k < q_bits.size()) begin
        obs_bits[W-1-k] = q_bits[r0 + k];
        load_n[W-1-k]   = !q_load[r0 + k];
`ifdef TRIROC_SC_READBACK_EN
        obs_rb[W-1-k]   = q_rb[r0 + k];
`endif
      end
    end
    check({p, "_edges"},     64'(rises - r0), 64'(W));
    check({p, "_bits"},      64'(obs_bits), 64'(exp_bits));
    check({p, "_ck_high"},   64'(ck_high - ch0), 64'(W * DIV));
    check({p, "_rstb_low"},  64'(rstb_low - rl0), rq ? 64'(RSTC) : 64'd0);
    check({p, "_rstb_pre"},  64'(q_rstb_at[r0] - rl0), rq ? 64'(RSTC) : 64'd0);
    check({p, "_load_edge"}, 64'(load_n), 64'd1);
    check({p, "_load_hold"}, 64'(load_low - q_loadlow_at[r0 + W - 1]), 64'(LH));
    check({p, "_load_pre"},  64'(q_loadlow_at[r0 + W - 1] > ll0), 64'd1);
    check({p, "_done_once"}, 64'(done_pulses - dp0), 64'd1);
    check({p, "_bad_rises"}, 64'(bad_rises - br0), 64'd0);
`ifdef TRIROC_SC_READBACK_EN
    check({p, "_tx_crc"}, 64'(tx_crc), 64'(crc_of(exp_bits)));
    check({p, "_rb_crc"}, 64'(rb_crc), 64'(crc_of(obs_rb)));
`else
    check({p, "_crc_zero"}, 64'({tx_crc, rb_crc}), 64'd0);
`endif
    tx_o = tx_crc;
    rb_o = rb_crc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] tx_a, rb_a, tx_b, rb_b;
    int r0, ll0, dp0, n;

    repeat (3) @(negedge ck_sys);
    check("reset_outputs", 64'({s_ready, busy, done, ck_sr, rstb_sr, sr_in, select, load_sc}),
          64'(8'b0000_1001));
    check("reset_crc", 64'({tx_crc, rb_crc}), 64'd0);
    rst_sys = 1'b0;
    repeat (2) @(negedge ck_sys);

    run_pass(1, 1'b0, 32'hA5A5A5A5, 32'hFF000000, 0, tx_a, rb_a);
    run_pass(2, 1'b1, 32'hA5A5A5A5, 32'hFF000000, 20, tx_a, rb_a);

    // Abandon a pass after 17 bits
    r0  = rises;
    ll0 = load_low;
    dp0 = done_pulses;
    s_data  = $urandom;
    s_valid = 1'b1;
    start   = 1'b1;
    @(negedge ck_sys);
    start = 1'b0;
    send_word(s_data, 0);
    n = 0;
    while ((rises - r0) < 17 && n < 1000) begin @(negedge ck_sys); #1; n++; end
    rst_sys = 1'b1;
    #1;
    check("abort_outputs", 64'({s_ready, busy, done, ck_sr, rstb_sr, sr_in, select, load_sc}),
          64'(8'b0000_1001));
    check("abort_crc", 64'({tx_crc, rb_crc}), 64'd0);
    repeat (3) @(negedge ck_sys);
    rst_sys = 1'b0;
    repeat (4) @(negedge ck_sys);
    check("abort_edges", 64'(rises - r0), 64'd17);
    check("abort_no_load", 64'(load_low - ll0), 64'd0);
    check("abort_no_done", 64'(done_pulses - dp0), 64'd0);

    run_pass(3, 1'($urandom_range(0, 1)), $urandom, $urandom, 0, tx_a, rb_a);

    run_pass(4, 1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A, 0, tx_a, rb_a);
    run_pass(5, 1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A, 0, tx_b, rb_b);
    check("readback_matches_tx", 64'(rb_b), 64'(tx_a));

    for (int i = 0; i < 3; i++)
      run_pass(6 + i, 1'($urandom_range(0, 1)), $urandom, $urandom,
               int'($urandom_range(0, 30)), tx_b, rb_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
